cds_sample_accumulator: RTL and testbench

- Sits directly downstream of the CDS clock generator and upstream of the host readout FIFO.
- While cds_clk1 is high, sums valid ADC samples into the reset-level sum; while cds_clk2 is high, sums them into the signal-level sum.
- On cds_done, computes the signed correlated-double-sample difference (sum2 - sum1) with both sample counts and queues the record in a 4-deep show-ahead output buffer with a valid/ready handshake.
- Runs in the 20 MHz ADC clock domain, the same clock as the CDS clock generator.

---
 rtl/cds_sample_accumulator_if.sv | 33 +++
 rtl/cds_sample_accumulator.sv | 206 ++++++++++++++++++++
 tb/tb_cds_sample_accumulator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cds_sample_accumulator_if.sv
// Bundle between the CDS sample accumulator and its environment: CDS window
// controls, ADC sample stream, record readout handshake and sticky status flags.
interface cds_sample_accumulator_if #(
  parameter int ADC_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 cds_clk1;
  logic                 cds_clk2;
  logic                 cds_done;
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 adc_valid;
  logic [ACC_WIDTH:0]   out_diff;
  logic [CNT_WIDTH-1:0] out_n1;
  logic [CNT_WIDTH-1:0] out_n2;
  logic                 out_valid;
  logic                 out_ready;
  logic                 count_mismatch;
  logic                 seq_error;
  logic                 overflow;

  // Environment side: drives the CDS windows and samples, consumes records.
  modport master (
    output cds_clk1, cds_clk2, cds_done, adc_data, adc_valid, out_ready,
    input  out_diff, out_n1, out_n2, out_valid, count_mismatch, seq_error, overflow
  );

  // Accumulator side.
  modport slave (
    input  cds_clk1, cds_clk2, cds_done, adc_data, adc_valid, out_ready,
    output out_diff, out_n1, out_n2, out_valid, count_mismatch, seq_error, overflow
  );
endinterface

// File: rtl/cds_sample_accumulator.sv
// Correlated double sampling accumulator: sums ADC samples in the reset and signal
// windows, then queues {sum2 - sum1, n1, n2} in a small show-ahead record buffer.
module cds_sample_accumulator #(
  parameter int ADC_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  cds_sample_accumulator_if.slave bus
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int REC_WIDTH = ACC_WIDTH + 1 + 2 * CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;
  localparam logic [PTR_WIDTH:0]     CNT_FULL = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    GAP,
    ACC2,
    WAIT_DONE,
    PUSH
  } state_t;

  state_t               state_reg;
  logic [ACC_WIDTH-1:0] acc1_reg;
  logic [ACC_WIDTH-1:0] acc2_reg;
  logic [CNT_WIDTH-1:0] n1_reg;
  logic [CNT_WIDTH-1:0] n2_reg;
  logic                 seq_error_reg;
  logic                 count_mismatch_reg;
  logic                 overflow_reg;

  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] acc1_sum;
  logic [ACC_WIDTH-1:0] acc2_sum;
  logic [CNT_WIDTH-1:0] n1_inc;
  logic [CNT_WIDTH-1:0] n2_inc;

  assign sample_ext = ACC_WIDTH'(bus.adc_data);
  assign acc1_sum   = acc1_reg + sample_ext;
  assign acc2_sum   = acc2_reg + sample_ext;
  // Counters hold at all-ones rather than wrapping.
  assign n1_inc     = (n1_reg == CNT_MAX) ? n1_reg : n1_reg + CNT_WIDTH'(1);
  assign n2_inc     = (n2_reg == CNT_MAX) ? n2_reg : n2_reg + CNT_WIDTH'(1);

  // ------------------------------------------------------------------
  // Window sequencing and accumulation
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      acc1_reg           <= '0;
      acc2_reg           <= '0;
      n1_reg             <= '0;
      n2_reg             <= '0;
      seq_error_reg      <= 1'b0;
      count_mismatch_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cds_clk1) begin
            state_reg <= ACC1;
            acc1_reg  <= bus.adc_valid ? sample_ext : '0;
            n1_reg    <= bus.adc_valid ? CNT_WIDTH'(1) : '0;
            acc2_reg  <= '0;
            n2_reg    <= '0;
          end else if (bus.cds_clk2 || bus.cds_done) begin
            seq_error_reg <= 1'b1;
          end
        end

        ACC1: begin
          if (bus.cds_clk1) begin
            if (bus.adc_valid) begin
              acc1_reg <= acc1_sum;
              n1_reg   <= n1_inc;
            end
          end else begin
            state_reg <= GAP;
          end
        end

        GAP: begin
          if (bus.cds_clk1 || bus.cds_done) begin
            seq_error_reg <= 1'b1;
            state_reg     <= IDLE;
          end else if (bus.cds_clk2) begin
            state_reg <= ACC2;
            if (bus.adc_valid) begin
              acc2_reg <= acc2_sum;
              n2_reg   <= n2_inc;
            end
          end
        end

        ACC2: begin
          if (bus.cds_clk2) begin
            if (bus.adc_valid) begin
              acc2_reg <= acc2_sum;
              n2_reg   <= n2_inc;
            end
          end else if (bus.cds_done) begin
            // cds_done coincident with the window 2 falling edge is legal.
            state_reg <= PUSH;
          end else begin
            state_reg <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (bus.cds_done) begin
            state_reg <= PUSH;
          end else if (bus.cds_clk1 || bus.cds_clk2) begin
            seq_error_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        PUSH: begin
          state_reg <= IDLE;
          if (n1_reg != n2_reg) begin
            count_mismatch_reg <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Show-ahead record buffer
  // ------------------------------------------------------------------
  logic [REC_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_reg;
  logic [PTR_WIDTH-1:0] rd_ptr_reg;
  logic [PTR_WIDTH:0]   count_reg;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 drop;
  logic [ACC_WIDTH:0]   diff;
  logic [REC_WIDTH-1:0] rec_in;
  logic [REC_WIDTH-1:0] head;

  assign diff    = {1'b0, acc2_reg} - {1'b0, acc1_reg};
  assign rec_in  = {diff, n1_reg, n2_reg};
  assign push    = (state_reg == PUSH);
  assign pop     = bus.out_valid && bus.out_ready;
  assign full    = (count_reg == CNT_FULL);
  // A full buffer still takes a record when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
          mem_reg[gi] <= rec_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (PTR_WIDTH + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_WIDTH + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign head               = mem_reg[rd_ptr_reg];
  assign bus.out_diff       = head[REC_WIDTH-1 -: ACC_WIDTH+1];
  assign bus.out_n1         = head[2*CNT_WIDTH-1 -: CNT_WIDTH];
  assign bus.out_n2         = head[CNT_WIDTH-1:0];
  assign bus.out_valid      = (count_reg != '0);
  assign bus.count_mismatch = count_mismatch_reg;
  assign bus.seq_error      = seq_error_reg;
  assign bus.overflow       = overflow_reg;

endmodule

// File: tb/tb_cds_sample_accumulator.sv
// Randomized bench for cds_sample_accumulator: drives whole CDS sequences and
// checks every cycle against a record-level queue model.
module tb_cds_sample_accumulator;

  localparam int DEPTH = 4;

  typedef struct {
    logic [32:0] diff;
    int          n1;
    int          n2;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cds_sample_accumulator_if #(.ADC_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(16)) ifc ();

  cds_sample_accumulator #(
    .ADC_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #25 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t pending_rec;
  bit   push_pending = 0;
  bit   exp_ovf = 0;
  bit   exp_mm = 0;
  bit   exp_seq = 0;
  bit   rand_ready = 0;

  logic [15:0] s1[16];
  logic [15:0] s2[16];
  bit          v1[16];
  bit          v2[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: update the model with what this edge does, then compare.
  task automatic tick();
    bit pop;
    if (rand_ready) ifc.out_ready = ($urandom_range(0, 2) != 0);
    pop = (exp_q.size() != 0) && ifc.out_ready;
    if (reset) begin
      exp_q.delete();
      push_pending = 0;
      exp_ovf = 0;
      exp_mm = 0;
      exp_seq = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push_pending) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pending_rec);
        else exp_ovf = 1;
        if (pending_rec.n1 != pending_rec.n2) exp_mm = 1;
        push_pending = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", ifc.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_diff", ifc.out_diff, exp_q[0].diff);
      check("out_n1", ifc.out_n1, exp_q[0].n1);
      check("out_n2", ifc.out_n2, exp_q[0].n2);
    end
    check("overflow", ifc.overflow, exp_ovf);
    check("count_mismatch", ifc.count_mismatch, exp_mm);
    check("seq_error", ifc.seq_error, exp_seq);
  endtask

  task automatic idle_inputs();
    ifc.cds_clk1  = 0;
    ifc.cds_clk2  = 0;
    ifc.cds_done  = 0;
    ifc.adc_valid = 0;
    ifc.adc_data  = 16'($urandom);
  endtask

  // Full legal sequence using s1/v1 and s2/v2; the expected record is the
  // plain sum of the valid samples in each window.
  task automatic run_seq(input int len1, input int gap, input int len2,
                         input int wait_n, input bit early);
    longint a1 = 0;
    longint a2 = 0;
    longint d;
    int c1 = 0;
    int c2 = 0;
    for (int i = 0; i < len1; i++) begin
      ifc.cds_clk1 = 1; ifc.adc_data = s1[i]; ifc.adc_valid = v1[i];
      if (v1[i]) begin a1 += s1[i]; c1++; end
      tick();
    end
    ifc.cds_clk1 = 0;
    for (int i = 0; i < gap; i++) begin
      ifc.adc_data = 16'($urandom); ifc.adc_valid = $urandom_range(0, 1) == 1;
      tick();
    end
    for (int i = 0; i < len2; i++) begin
      ifc.cds_clk2 = 1; ifc.adc_data = s2[i]; ifc.adc_valid = v2[i];
      if (v2[i]) begin a2 += s2[i]; c2++; end
      tick();
    end
    ifc.cds_clk2 = 0;
    if (!early) begin
      for (int i = 0; i <= wait_n; i++) begin
        ifc.adc_data = 16'($urandom); ifc.adc_valid = $urandom_range(0, 1) == 1;
        tick();
      end
    end
    ifc.cds_done = 1; ifc.adc_valid = $urandom_range(0, 1) == 1;
    tick();
    idle_inputs();
    a1 = a1 & 64'hFFFF_FFFF;
    a2 = a2 & 64'hFFFF_FFFF;
    d = a2 - a1;
    pending_rec.diff = d[32:0];
    pending_rec.n1   = (c1 > 65535) ? 65535 : c1;
    pending_rec.n2   = (c2 > 65535) ? 65535 : c2;
    push_pending = 1;
    tick();
  endtask

  task automatic load_const(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      s1[i] = a; s2[i] = b; v1[i] = 1; v2[i] = 1;
    end
  endtask

  task automatic nominal();
    load_const(100, 500);
    s1[2] = 102; s1[3] = 98;
    run_seq(4, 1, 4, 0, 0);
  endtask

  initial begin
    idle_inputs();
    ifc.out_ready = 1;
    reset = 1;
    tick();
    tick();
    reset = 0;
    check("rst_diff", ifc.out_diff, 0);
    check("rst_n1", ifc.out_n1, 0);
    check("rst_n2", ifc.out_n2, 0);

    // Nominal: expect +1600, 4/4
    nominal();
    check("nom_diff", ifc.out_diff, 33'd1600);
    tick();

    // Negative difference: 20 - 2000 = -1980
    load_const(1000, 10);
    run_seq(2, 2, 2, 1, 0);
    check("neg_diff", ifc.out_diff, 33'h1_FFFF_F844);
    repeat (2) tick();

    // Back-pressure: four held, fifth dropped, then in-order drain
    ifc.out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      load_const(16'(100 + k), 16'(500 + 7 * k));
      run_seq(4, 1, 4, 0, k[0]);
    end
    check("ovf_set", ifc.overflow, 1);
    ifc.out_ready = 1;
    repeat (6) tick();

    // Window 2 with no window 1, then a good sequence
    ifc.cds_clk2 = 1;
    exp_seq = 1;
    repeat (3) tick();
    ifc.cds_clk2 = 0;
    tick();
    nominal();
    repeat (2) tick();

    // One window-2 sample invalid: 1500 - 400 = 1100, n2 = 3
    load_const(100, 500);
    v2[1] = 0;
    run_seq(4, 1, 4, 0, 1);
    check("mm_diff", ifc.out_diff, 33'd1100);
    repeat (2) tick();

    // Reset in the middle of window 2
    load_const(300, 700);
    ifc.cds_clk1 = 1; ifc.adc_valid = 1; ifc.adc_data = 300;
    repeat (2) tick();
    ifc.cds_clk1 = 0;
    tick();
    ifc.cds_clk2 = 1; ifc.adc_data = 700;
    repeat (2) tick();
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    check("mid_rst_diff", ifc.out_diff, 0);
    check("mid_rst_n1", ifc.out_n1, 0);
    check("mid_rst_n2", ifc.out_n2, 0);
    check("mid_rst_valid", ifc.out_valid, 0);
    tick();
    nominal();
    check("post_rst_diff", ifc.out_diff, 33'd1600);
    repeat (2) tick();

    // Randomized sequences with random back-pressure
    rand_ready = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) begin
        s1[i] = 16'($urandom); s2[i] = 16'($urandom);
        v1[i] = $urandom_range(0, 3) != 0; v2[i] = $urandom_range(0, 3) != 0;
      end
      run_seq($urandom_range(1, 8), $urandom_range(1, 3), $urandom_range(1, 8),
              $urandom_range(0, 2), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 0;
    ifc.out_ready = 1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
